// File: rtl/serial_tx_sequencer.sv
// Frame sequencer for an asynchronous serial transmitter: pops one TX FIFO entry per frame
// and shifts it out as start/data/parity/stop bits with fractional (24.8) bit timing.
module serial_tx_sequencer #(
  parameter int C_BRD_WIDTH = 32
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic                   enable,
  input  logic [C_BRD_WIDTH-1:0] brd,
  input  logic [3:0]             data_bits,
  input  logic                   parity_en,
  input  logic                   parity_odd,
  input  logic                   stop2,
  input  logic                   fifo_empty,
  input  logic [8:0]             fifo_rd_data,
  output logic                   fifo_rd_request,
  output logic                   tx,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int IW = C_BRD_WIDTH - 8;

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] brd_int;
  logic [7:0]    brd_frac;
  logic [7:0]    frac_acc;
  logic [IW-1:0] bit_cnt;
  logic [8:0]    shift;
  logic [3:0]    data_left;
  logic          parity_bit;
  logic          par_en_q;
  logic          stop2_q;
  logic          stop_second;

  logic          go;
  logic          bit_end;
  logic          last_stop;
  logic [3:0]    n_clamp;
  logic [8:0]    mask;
  logic [8:0]    acc_sum;
  logic [IW:0]   len_m1;

  assign go        = enable && !fifo_empty && (brd[C_BRD_WIDTH-1:8] != '0);
  assign bit_end   = (bit_cnt == '0);
  assign last_stop = !stop2_q || stop_second;
  assign n_clamp   = (data_bits < 4'd5) ? 4'd5 : (data_bits > 4'd9) ? 4'd9 : data_bits;
  assign mask      = 9'h1FF >> (4'd9 - n_clamp);
  // Carry out of the fraction accumulator stretches the next bit by one clock.
  assign acc_sum   = {1'b0, frac_acc} + {1'b0, brd_frac};
  assign len_m1    = {1'b0, brd_int} + {{IW{1'b0}}, acc_sum[8]} - (IW+1)'(1);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = POP;
      POP:     state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && data_left == 4'd0) state_next = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (bit_end && last_stop) state_next = go ? POP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx              = 1'b1;
    busy            = (state != IDLE);
    fifo_rd_request = (state == POP);
    frame_done      = (state == STOP) && bit_end && last_stop;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      PARITY:  tx = parity_bit;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      brd_int     <= '0;
      brd_frac    <= '0;
      frac_acc    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data_left   <= '0;
      parity_bit  <= 1'b0;
      par_en_q    <= 1'b0;
      stop2_q     <= 1'b0;
      stop_second <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          shift       <= fifo_rd_data;
          data_left   <= n_clamp - 4'd1;
          parity_bit  <= (^(fifo_rd_data & mask)) ^ parity_odd;
          par_en_q    <= parity_en;
          stop2_q     <= stop2;
          stop_second <= 1'b0;
          brd_int     <= brd[C_BRD_WIDTH-1:8];
          brd_frac    <= brd[7:0];
          // Accumulator starts from zero; the first bit's add (0 + frac) can never carry.
          frac_acc    <= brd[7:0];
          bit_cnt     <= brd[C_BRD_WIDTH-1:8] - IW'(1);
        end
        START, DATA, PARITY, STOP: begin
          if (bit_end) begin
            frac_acc <= acc_sum[7:0];
            bit_cnt  <= len_m1[IW-1:0];
            if (state == DATA) begin
              shift     <= shift >> 1;
              data_left <= data_left - 4'd1;
            end
            if (state == STOP) stop_second <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Directed bench for serial_tx_sequencer: table of single-frame vectors plus hand-written
// sequences for back-to-back frames, enable drop, brd=0 and mid-frame reset.
module tb_serial_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] brd = 32'h0;
  logic [3:0]  data_bits = 4'd8;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic        fifo_empty;
  logic [8:0]  fifo_rd_data = 9'h0;
  logic        fifo_rd_request;
  logic        tx;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  serial_tx_sequencer #(.C_BRD_WIDTH(32)) dut (
    .S_AXI_ACLK      (clk),
    .S_AXI_ARESETN   (rst_n),
    .enable          (enable),
    .brd             (brd),
    .data_bits       (data_bits),
    .parity_en       (parity_en),
    .parity_odd      (parity_odd),
    .stop2           (stop2),
    .fifo_empty      (fifo_empty),
    .fifo_rd_data    (fifo_rd_data),
    .fifo_rd_request (fifo_rd_request),
    .tx              (tx),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  // FIFO model: head data registered one cycle after the pop request.
  logic [8:0] fmem [0:31];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rd_pulses = 0;
  int         empty_pops = 0;
  logic       fifo_clear = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_clear) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_request) begin
      if (rd_ptr == wr_ptr) empty_pops <= empty_pops + 1;
      else begin
        fifo_rd_data <= fmem[rd_ptr % 32];
        rd_ptr       <= rd_ptr + 1;
      end
    end
    if (fifo_rd_request) rd_pulses <= rd_pulses + 1;
  end

  typedef struct {
    logic [31:0] brd;
    logic [3:0]  db;
    logic        pe;
    logic        po;
    logic        s2;
    logic [8:0]  data;
    int          nbits;
    logic [15:0] bits;   // frame bits on the line, bit 0 = start bit
    int          len;    // total frame clocks
  } vec_t;

  vec_t vecs [7];
  int   n_vec = 0;
  int   n_bad = 0;
  logic wave [0:511];

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic push(input logic [8:0] d);
    fmem[wr_ptr % 32] = d;
    wr_ptr++;
  endtask

  task automatic flush();
    fifo_clear = 1'b1;
    @(negedge clk);
    fifo_clear = 1'b0;
  endtask

  task automatic wait_start(input string name, output int ok);
    ok = 0;
    for (int k = 0; k < 1000 && ok == 0; k++) begin
      @(negedge clk);
      if (tx == 1'b0) ok = 1;
    end
    if (ok == 0) check({name, "_start_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name, output int clocks);
    int ok;
    ok = 0;
    clocks = 0;
    for (int k = 0; k < 1000 && ok == 0; k++) begin
      @(negedge clk);
      clocks++;
      if (frame_done) ok = 1;
    end
    if (ok == 0) check({name, "_done_timeout"}, 0, 1);
  endtask

  initial begin
    int base, wlen, done, started, mism, idx, acc, sum, c, ok, clocks;

    vecs[0] = '{32'h400, 4'd8,  1'b0, 1'b0, 1'b0, 9'h055, 10, 16'h02AA, 40};
    vecs[1] = '{32'h280, 4'd8,  1'b0, 1'b0, 1'b0, 9'h000, 10, 16'h0200, 25};
    vecs[2] = '{32'h200, 4'd7,  1'b1, 1'b0, 1'b0, 9'h007, 10, 16'h030E, 20};
    vecs[3] = '{32'h200, 4'd7,  1'b1, 1'b1, 1'b0, 9'h007, 10, 16'h020E, 20};
    vecs[4] = '{32'h300, 4'd3,  1'b0, 1'b0, 1'b1, 9'h1F5,  8, 16'h00EA, 24};
    vecs[5] = '{32'h100, 4'd12, 1'b1, 1'b0, 1'b0, 9'h1AB, 12, 16'h0B56, 12};
    vecs[6] = '{32'h240, 4'd5,  1'b0, 1'b0, 1'b0, 9'h00A,  7, 16'h0054, 15};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_rd", int'(fifo_rd_request), 0);
    check("rst_done", int'(frame_done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-frame vectors; config inputs are scrambled once START is seen
    for (int v = 0; v < 7; v++) begin
      brd = vecs[v].brd; data_bits = vecs[v].db; parity_en = vecs[v].pe;
      parity_odd = vecs[v].po; stop2 = vecs[v].s2;
      push(vecs[v].data);
      base = rd_pulses;
      enable = 1'b1;
      started = 0; wlen = 0; done = 0;
      for (int k = 0; k < 2000 && done == 0; k++) begin
        @(negedge clk);
        if (started == 0 && tx == 1'b0) begin
          started = 1;
          brd = 32'h100; data_bits = 4'd5; parity_en = ~vecs[v].pe;
          parity_odd = ~vecs[v].po; stop2 = ~vecs[v].s2; enable = 1'b0;
        end
        if (started != 0 && wlen < 512) begin
          wave[wlen] = tx;
          wlen++;
        end
        if (frame_done) done = 1;
      end
      if (done == 0) check($sformatf("v%0d_timeout", v), 0, 1);
      mism = -1; idx = 0; acc = 0;
      for (int i = 0; i < vecs[v].nbits; i++) begin
        sum = acc + int'(vecs[v].brd[7:0]);
        c = sum >> 8;
        acc = sum & 255;
        for (int j = 0; j < int'(vecs[v].brd[31:8]) + c; j++) begin
          if (idx < wlen && mism < 0 && wave[idx] != vecs[v].bits[i]) mism = idx;
          idx++;
        end
      end
      check($sformatf("v%0d_len", v), wlen, vecs[v].len);
      check($sformatf("v%0d_wave_first_bad_clock", v), mism, -1);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_busy_after", v), int'(busy), 0);
      check($sformatf("v%0d_tx_after", v), int'(tx), 1);
      check($sformatf("v%0d_rd_pulses", v), rd_pulses - base, 1);
    end

    // Back-to-back frames with two stop bits: exactly POP and LOAD between them
    brd = 32'h200; data_bits = 4'd8; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b1;
    push(9'h055); push(9'h0AA);
    base = rd_pulses;
    enable = 1'b1;
    wait_start("b2b1", ok);
    wait_done("b2b1", clocks);
    check("b2b_frame1_len", clocks + 1, 22);
    @(negedge clk); check("b2b_pop_tx", int'(tx), 1);
    check("b2b_pop_rd", int'(fifo_rd_request), 1);
    @(negedge clk); check("b2b_load_tx", int'(tx), 1);
    @(negedge clk); check("b2b_start_tx", int'(tx), 0);
    wait_done("b2b2", clocks);
    check("b2b_frame2_len", clocks + 1, 22);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b_rd_pulses", rd_pulses - base, 2);
    check("b2b_idle", int'(busy), 0);

    // Enable dropped during data bit 3: frame completes, no further pop
    flush();
    stop2 = 1'b0;
    push(9'h0FF); push(9'h0FF);
    base = rd_pulses;
    enable = 1'b1;
    wait_start("endrop", ok);
    repeat (8) @(negedge clk);
    check("endrop_bit3_tx", int'(tx), 1);
    enable = 1'b0;
    wait_done("endrop", clocks);
    check("endrop_frame_len", clocks + 9, 20);
    repeat (10) @(negedge clk);
    check("endrop_busy", int'(busy), 0);
    check("endrop_rd_pulses", rd_pulses - base, 1);
    check("endrop_fifo_nonempty", int'(fifo_empty), 0);

    // Zero integer divisor never starts a frame
    brd = 32'h0FF;
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("brd0_rd_pulses", rd_pulses - base, 1);
    check("brd0_busy", int'(busy), 0);
    enable = 1'b0;
    flush();

    // Reset during DATA aborts the frame immediately
    brd = 32'h200;
    push(9'h000);
    base = rd_pulses;
    enable = 1'b1;
    wait_start("rst", ok);
    repeat (4) @(negedge clk);
    check("rst_pre_tx", int'(tx), 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", int'(tx), 1);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(frame_done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_after_busy", int'(busy), 0);
    check("rst_after_tx", int'(tx), 1);
    check("rst_after_rd_pulses", rd_pulses - base, 1);
    check("empty_pops", empty_pops, 0);
    enable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_tx_sequencer.md
SERIAL_TX_SEQUENCER -- requirements
Module: serial_tx_sequencer

Interface
REQ-001 SHALL have parameter C_BRD_WIDTH, default 32, meaning baud divisor width in 24.8 fixed point (integer [31:8], fraction [7:0]).
REQ-002 SHALL have port S_AXI_ACLK  in  1  single clock; all state on its rising edge.
REQ-003 SHALL have port S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port enable  in  1  transmitter enable.
REQ-005 SHALL have port brd  in  C_BRD_WIDTH  clocks per bit, 24.8 fixed point.
REQ-006 SHALL have port data_bits  in  4  frame data length, 5..9.
REQ-007 SHALL have ports parity_en and parity_odd  in  1 each  parity enable, odd parity select.
REQ-008 SHALL have port stop2  in  1  two stop bits when 1.
REQ-009 SHALL have port fifo_empty  in  1  TX FIFO empty flag.
REQ-010 SHALL have port fifo_rd_data  in  9  FIFO head data, valid one cycle after fifo_rd_request.
REQ-011 SHALL have port fifo_rd_request  out  1  one-cycle FIFO pop pulse.
REQ-012 SHALL have port tx  out  1  serial line, idle high.
REQ-013 SHALL have ports busy and frame_done  out  1 each  frame in progress; one-cycle pulse at frame end.

Function
REQ-014 SHALL implement states IDLE, POP, LOAD, START, DATA, PARITY, STOP.
REQ-015 IDLE SHALL go to POP when enable=1, fifo_empty=0, brd[31:8]!=0; otherwise stay in IDLE.
REQ-016 fifo_rd_request SHALL be 1 only in POP, exactly one cycle; POP SHALL always go to LOAD.
REQ-017 LOAD SHALL capture fifo_rd_data, data_bits, parity_en, parity_odd, stop2, brd, then go to START; input changes after LOAD SHALL NOT affect the current frame.
REQ-018 data_bits <5 SHALL be treated as 5 and >9 as 9; bits SHALL be sent LSB first, from fifo_rd_data[n-1:0].
REQ-019 Parity bit SHALL be the XOR of the sent data bits (even parity), inverted when parity_odd=1; the PARITY state SHALL be skipped when parity_en=0.
REQ-020 tx SHALL be 0 in START, the data bit in DATA, the parity bit in PARITY, and 1 in all other states.
REQ-021 Each bit SHALL last brd[31:8]+c clocks, where c is the carry out of an 8-bit fraction accumulator that adds brd[7:0] once per bit; the accumulator SHALL clear in LOAD.
REQ-022 STOP SHALL last one bit period, or two bit periods when stop2=1; frame_done SHALL pulse in the last STOP cycle.
REQ-023 In the last STOP cycle, the next state SHALL be POP when the REQ-015 conditions hold, else IDLE; back-to-back frames SHALL have exactly 2 extra tx=1 cycles (POP, LOAD).
REQ-024 Deasserting enable mid-frame SHALL complete the current frame, then return to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 fifo_rd_request SHALL never assert while fifo_empty=1 was sampled in the deciding cycle.

Reset
REQ-027 When S_AXI_ARESETN=0, all state SHALL clear immediately: state=IDLE, tx=1, fifo_rd_request=0, busy=0, frame_done=0, fraction accumulator=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with tx=1, pop no further entries, and lose the in-flight character.

Verification
REQ-029 brd=0x400, 8N1, one entry 0x055 -> one rd pulse; tx low 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks; frame_done at clock 40 of the frame.
REQ-030 brd=0x280, 8N1, entry 0x000 -> bit lengths alternate 2,3 (first bit 2); total frame 25 clocks.
REQ-031 brd=0x200, data_bits=7, parity_en=1, parity_odd=0, entry 0x007 -> parity bit 1; with parity_odd=1 -> parity bit 0; total 10 bits = 20 clocks.
REQ-032 Two entries, brd=0x200, stop2=1 -> second start bit begins exactly 2 cycles after the first frame's final STOP cycle; exactly two rd pulses.
REQ-033 Drop enable during DATA bit 3 -> frame completes, state returns to IDLE, no further pop although fifo_empty=0; brd=0x0 with fifo_empty=0 -> no pop.
REQ-034 Assert reset during DATA -> tx=1, busy=0 in the same cycle; after release with fifo_empty=1, the block stays in IDLE.
